// File: rtl/flappy_pkg.sv
// Shared defaults and state encoding for the flappy-style pipe field.
package flappy_pkg;
  localparam int DEF_NUM_COLS     = 16;
  localparam int ROWS             = 8;
  localparam int DEF_BIRD_COL     = 2;
  localparam int DEF_PIPE_SPACING = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FROZEN = 2'd2
  } scroll_state_e;
endpackage

// File: rtl/column_shifter.sv
// Field of NUM_COLS columns that shifts toward column 0; new data enters at the top column.
module column_shifter
  import flappy_pkg::*;
#(
  parameter int NUM_COLS = DEF_NUM_COLS
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     clear,
  input  logic                     shift,
  input  logic [ROWS-1:0]          din,
  output logic [NUM_COLS*ROWS-1:0] field
);
  logic [ROWS-1:0] col_q [NUM_COLS];

  for (genvar i = 0; i < NUM_COLS; i++) begin : g_col
    logic [ROWS-1:0] col_d;
    if (i == NUM_COLS - 1) begin : g_top
      assign col_d = din;
    end else begin : g_mid
      assign col_d = col_q[i+1];
    end

    always_ff @(posedge Clock) begin
      if (Reset || clear)  col_q[i] <= '0;
      else if (shift)      col_q[i] <= col_d;
    end

    assign field[i*ROWS +: ROWS] = col_q[i];
  end
endmodule

// File: rtl/pipe_scroller.sv
// Scroll controller: run/freeze FSM, pipe spacing counter, pass detection and field readout.
module pipe_scroller
  import flappy_pkg::*;
#(
  parameter int NUM_COLS     = DEF_NUM_COLS,
  parameter int PIPE_SPACING = DEF_PIPE_SPACING,
  parameter int BIRD_COL     = DEF_BIRD_COL,
  // One extra address bit so that out-of-range selects are expressible.
  parameter int SEL_W        = $clog2(NUM_COLS + 1)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             start,
  input  logic             stop,
  input  logic             tick,
  input  logic [ROWS-1:0]  pattern_in,
  output logic             pattern_en,
  input  logic [SEL_W-1:0] col_sel,
  output logic [ROWS-1:0]  col_data,
  output logic [ROWS-1:0]  bird_col_data,
  output logic             pass_pulse,
  output logic             running
);
  localparam int CNT_W = (PIPE_SPACING > 1) ? $clog2(PIPE_SPACING) : 1;
  localparam int IDX_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

  scroll_state_e           state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    pass_q;
  logic [NUM_COLS*ROWS-1:0] field;
  logic [ROWS-1:0]         cols [NUM_COLS];

  logic enter_run, do_shift, cnt_zero;
  logic [ROWS-1:0] din;

  assign running   = (state_q == S_RUN);
  assign enter_run = (state_q != S_RUN) && start;
  // stop beats a coincident tick: nothing moves on the freezing edge.
  assign do_shift  = running && tick && !stop;
  assign cnt_zero  = (cnt_q == '0);
  assign din       = cnt_zero ? pattern_in : '0;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      pass_q <= 1'b0;
      case (state_q)
        S_IDLE, S_FROZEN: begin
          if (start) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
          end
        end
        S_RUN: begin
          if (stop) begin
            state_q <= S_FROZEN;
          end else if (tick) begin
            cnt_q  <= (cnt_q == CNT_W'(PIPE_SPACING - 1)) ? '0 : cnt_q + 1'b1;
            pass_q <= (cols[BIRD_COL] != '0);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  column_shifter #(.NUM_COLS(NUM_COLS)) u_shifter (
    .Clock (Clock),
    .Reset (Reset),
    .clear (enter_run),
    .shift (do_shift),
    .din   (din),
    .field (field)
  );

  for (genvar i = 0; i < NUM_COLS; i++) begin : g_unpack
    assign cols[i] = field[i*ROWS +: ROWS];
  end

  always_comb begin
    col_data = '0;
    if (int'(col_sel) < NUM_COLS) col_data = cols[col_sel[IDX_W-1:0]];
  end

  assign bird_col_data = cols[BIRD_COL];
  assign pattern_en    = running && cnt_zero;
  assign pass_pulse    = pass_q;
endmodule

// File: tb/tb_pipe_scroller.sv
// Randomized bench: a queue-based field model feeds a scoreboard checked by a separate monitor.
module tb_pipe_scroller;
  localparam int N  = 16;
  localparam int SP = 4;
  localparam int BC = 2;
  localparam int SW = 5;

  logic          Clock = 1'b0;
  logic          Reset, start, stop, tick;
  logic [7:0]    pattern_in;
  logic          pattern_en;
  logic [SW-1:0] col_sel;
  logic [7:0]    col_data, bird_col_data;
  logic          pass_pulse, running;

  always #5 Clock = ~Clock;

  pipe_scroller #(.NUM_COLS(N), .PIPE_SPACING(SP), .BIRD_COL(BC), .SEL_W(SW)) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .start         (start),
    .stop          (stop),
    .tick          (tick),
    .pattern_in    (pattern_in),
    .pattern_en    (pattern_en),
    .col_sel       (col_sel),
    .col_data      (col_data),
    .bird_col_data (bird_col_data),
    .pass_pulse    (pass_pulse),
    .running       (running)
  );

  typedef struct {
    logic       run;
    logic       pen;
    logic       pass;
    logic [7:0] cd;
    logic [7:0] bird;
    int         sel;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: mode 0=idle 1=run 2=frozen, field as a queue (index 0 = oldest column).
  int         m_st;
  logic [7:0] m_f[$];
  int         m_nt;
  logic       m_pass;

  function automatic void m_clear_field();
    m_f.delete();
    for (int i = 0; i < N; i++) m_f.push_back(8'h00);
    m_nt = 0;
  endfunction

  task automatic chk(input string nm, input int sel, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (sel=%0d) @%0t: got %h expected %h", nm, sel, $time, act, exp);
    end
  endtask

  always @(negedge Clock) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("running",       e.sel, {7'd0, running},    {7'd0, e.run});
      chk("pattern_en",    e.sel, {7'd0, pattern_en}, {7'd0, e.pen});
      chk("pass_pulse",    e.sel, {7'd0, pass_pulse}, {7'd0, e.pass});
      chk("col_data",      e.sel, col_data,           e.cd);
      chk("bird_col_data", e.sel, bird_col_data,      e.bird);
    end
  end

  task automatic step(input bit r, input bit s, input bit p, input bit t,
                      input logic [7:0] pat, input int sel);
    exp_t e;
    Reset = r; start = s; stop = p; tick = t; pattern_in = pat; col_sel = SW'(sel);
    e.run  = (m_st == 1);
    e.pen  = e.run && (m_nt % SP == 0);
    e.pass = m_pass;
    e.cd   = (sel < N) ? m_f[sel] : 8'h00;
    e.bird = m_f[BC];
    e.sel  = sel;
    sbq.push_back(e);
    m_pass = 1'b0;
    if (r) begin
      m_st = 0;
      m_clear_field();
    end else if (m_st == 1) begin
      if (p) m_st = 2;
      else if (t) begin
        m_pass = (m_f[BC] != 8'h00);
        void'(m_f.pop_front());
        m_f.push_back((m_nt % SP == 0) ? pat : 8'h00);
        m_nt++;
      end
    end else if (s) begin
      m_st = 1;
      m_clear_field();
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic sweep(input logic [7:0] pat);
    for (int s = 0; s <= N; s++) step(0, 0, 0, 0, pat, s);
  endtask

  initial begin
    Reset = 1'b1; start = 0; stop = 0; tick = 0; pattern_in = 8'h00; col_sel = '0;
    m_st = 0; m_pass = 1'b0; m_clear_field();
    @(posedge Clock);
    #1;
    step(1, 0, 0, 0, 8'h00, 0);
    step(0, 1, 0, 0, 8'h00, 0);
    sweep(8'h9F);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 8'h9F, 15 - k);
    sweep(8'h9F);
    for (int k = 0; k < 14; k++) step(0, 0, 0, 1, 8'h00, (k * 3) % 17);
    step(0, 0, 0, 0, 8'h00, 2);
    step(0, 0, 0, 0, 8'h00, 3);
    // freeze on coincident stop/tick, then ticks must be ignored
    step(0, 0, 1, 1, 8'hFF, 3);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 8'hFF, k);
    sweep(8'h00);
    step(0, 1, 1, 0, 8'h00, 0);
    sweep(8'h00);
    // fill then reset mid-run
    for (int k = 0; k < 12; k++) step(0, 0, 0, 1, 8'($urandom_range(1, 255)), 15);
    step(1, 0, 0, 1, 8'hAA, 15);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 8'hAA, 15);
    step(0, 1, 0, 0, 8'h00, 0);
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 55,
           8'($urandom), $urandom_range(0, 20));
    end
    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(negedge Clock);
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
